phy_init_seq: RTL and testbench

Parametrised PHY bring-up sequencer for the RGMII MAC core. Holds the PHY in reset for a programmable time and generates the MDC reference clock. It then issues a table of MDIO register writes through the existing valid/ready MDIO engine and polls a link-status register forever. It exports link_up, init_done and error status to the core logic.

---
 rtl/phy_init_seq_if.sv | 19 +
 rtl/phy_init_seq.sv | 192 +++++++++++++++++++
 tb/tb_phy_init_seq.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/phy_init_seq_if.sv
// MDIO request/response channel between the PHY init sequencer and the MDIO engine.
interface phy_init_seq_if;
    logic        mdio_valid;
    logic        mdio_write;
    logic [4:0]  mdio_phy_addr;
    logic [4:0]  mdio_addr;
    logic [15:0] mdio_wdata;
    logic        mdio_ready;
    logic [15:0] mdio_rdata;

    modport master (
        output mdio_valid, mdio_write, mdio_phy_addr, mdio_addr, mdio_wdata,
        input  mdio_ready, mdio_rdata
    );
    modport slave (
        input  mdio_valid, mdio_write, mdio_phy_addr, mdio_addr, mdio_wdata,
        output mdio_ready, mdio_rdata
    );
endinterface

// File: rtl/phy_init_seq.sv
// PHY bring-up sequencer: reset hold/settle, MDIO init-table writes, then
// periodic link-status polling with sticky timeout error and link change count.
module phy_init_seq #(
    parameter int          CLK_FREQ_HZ      = 125000000,
    parameter int          RESET_HOLD_US    = 100000,
    parameter int          RESET_WAIT_US    = 10000,
    parameter int          MDC_FREQ_HZ      = 2500000,
    parameter logic [4:0]  PHY_ADDR         = 5'b00100,
    parameter int          NUM_INIT         = 2,
    parameter logic [21*((NUM_INIT > 0) ? NUM_INIT : 1)-1:0] INIT_TABLE = '0,
    parameter logic [4:0]  POLL_REG         = 5'd1,
    parameter logic [15:0] POLL_MASK        = 16'h0004,
    parameter int          POLL_INTERVAL_US = 1000,
    parameter int          MDIO_TIMEOUT     = 65535
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           restart,
    output logic           phy_reset_n,
    output logic           mdc_clk,
    phy_init_seq_if.master mdio,
    output logic           init_done,
    output logic           link_up,
    output logic [7:0]     link_changes,
    output logic           error
);
    localparam int CYC_PER_US = CLK_FREQ_HZ / 1000000;
    localparam int HALF       = CLK_FREQ_HZ / MDC_FREQ_HZ / 2;
    localparam int CYC_W      = $clog2(CYC_PER_US + 1);
    localparam int MDC_W      = $clog2(HALF + 1);
    localparam int US_MAX0    = (RESET_HOLD_US > RESET_WAIT_US) ? RESET_HOLD_US : RESET_WAIT_US;
    localparam int US_MAX     = (US_MAX0 > POLL_INTERVAL_US) ? US_MAX0 : POLL_INTERVAL_US;
    localparam int US_W       = $clog2(US_MAX + 1);
    localparam int TO_W       = $clog2(MDIO_TIMEOUT + 1);
    localparam int IDX_W      = (NUM_INIT > 0) ? $clog2(NUM_INIT + 1) : 1;

    typedef enum logic [2:0] {
        S_HOLD, S_WAIT, S_WR_REQ, S_WR_BUSY, S_POLL_GAP, S_RD_REQ, S_RD_BUSY
    } state_t;

    state_t           state;
    logic [CYC_W-1:0] tick_cnt;
    logic [US_W-1:0]  us_cnt;
    logic [US_W-1:0]  us_last;
    logic [TO_W-1:0]  to_cnt;
    logic [IDX_W-1:0] idx;
    logic [MDC_W-1:0] mdc_cnt;
    logic [20:0]      entry;
    logic             tick;
    logic             us_done;
    logic             timeout;
    logic             link_new;

    assign tick     = (tick_cnt == CYC_W'(CYC_PER_US - 1));
    assign us_done  = tick && (us_cnt == us_last);
    assign timeout  = (to_cnt == TO_W'(MDIO_TIMEOUT - 1));
    assign link_new = |(mdio.mdio_rdata & POLL_MASK);
    assign mdio.mdio_phy_addr = PHY_ADDR;

    always_comb begin
        us_last = US_W'(POLL_INTERVAL_US - 1);
        case (state)
            S_HOLD:  us_last = US_W'(RESET_HOLD_US - 1);
            S_WAIT:  us_last = US_W'(RESET_WAIT_US - 1);
            default: us_last = US_W'(POLL_INTERVAL_US - 1);
        endcase
    end

    always_comb begin
        entry = '0;
        for (int i = 0; i < NUM_INIT; i++)
            if (idx == IDX_W'(i)) entry = INIT_TABLE[21*i +: 21];
    end

    // MDC is free-running and only stopped by the hard reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdc_cnt <= '0;
            mdc_clk <= 1'b1;
        end else if (mdc_cnt == MDC_W'(HALF - 1)) begin
            mdc_cnt <= '0;
            mdc_clk <= ~mdc_clk;
        end else begin
            mdc_cnt <= mdc_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_HOLD;
            tick_cnt        <= '0;
            us_cnt          <= '0;
            to_cnt          <= '0;
            idx             <= '0;
            phy_reset_n     <= 1'b0;
            mdio.mdio_valid <= 1'b0;
            mdio.mdio_write <= 1'b0;
            mdio.mdio_addr  <= '0;
            mdio.mdio_wdata <= '0;
            init_done       <= 1'b0;
            link_up         <= 1'b0;
            link_changes    <= '0;
            error           <= 1'b0;
        end else if (restart) begin
            // error and link_changes deliberately survive a restart
            state           <= S_HOLD;
            tick_cnt        <= '0;
            us_cnt          <= '0;
            to_cnt          <= '0;
            idx             <= '0;
            phy_reset_n     <= 1'b0;
            mdio.mdio_valid <= 1'b0;
            mdio.mdio_write <= 1'b0;
            mdio.mdio_addr  <= '0;
            mdio.mdio_wdata <= '0;
            init_done       <= 1'b0;
            link_up         <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (tick) us_cnt <= us_cnt + 1'b1;
            case (state)
                S_HOLD: if (us_done) begin
                    state       <= S_WAIT;
                    phy_reset_n <= 1'b1;
                    tick_cnt    <= '0;
                    us_cnt      <= '0;
                end
                S_WAIT: if (us_done) begin
                    tick_cnt <= '0;
                    us_cnt   <= '0;
                    if (NUM_INIT > 0) begin
                        state <= S_WR_REQ;
                    end else begin
                        state     <= S_POLL_GAP;
                        init_done <= 1'b1;
                    end
                end
                S_WR_REQ: begin
                    mdio.mdio_valid <= 1'b1;
                    mdio.mdio_write <= 1'b1;
                    mdio.mdio_addr  <= entry[20:16];
                    mdio.mdio_wdata <= entry[15:0];
                    to_cnt          <= '0;
                    state           <= S_WR_BUSY;
                end
                S_WR_BUSY: if (mdio.mdio_ready || timeout) begin
                    if (!mdio.mdio_ready) error <= 1'b1;
                    mdio.mdio_valid <= 1'b0;
                    idx             <= idx + 1'b1;
                    if (idx == IDX_W'(NUM_INIT - 1)) begin
                        init_done <= 1'b1;
                        state     <= S_POLL_GAP;
                        tick_cnt  <= '0;
                        us_cnt    <= '0;
                    end else begin
                        state <= S_WR_REQ;
                    end
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
                S_POLL_GAP: if (us_done) begin
                    state    <= S_RD_REQ;
                    tick_cnt <= '0;
                    us_cnt   <= '0;
                end
                S_RD_REQ: begin
                    mdio.mdio_valid <= 1'b1;
                    mdio.mdio_write <= 1'b0;
                    mdio.mdio_addr  <= POLL_REG;
                    mdio.mdio_wdata <= '0;
                    to_cnt          <= '0;
                    state           <= S_RD_BUSY;
                end
                S_RD_BUSY: if (mdio.mdio_ready || timeout) begin
                    if (mdio.mdio_ready) begin
                        link_up <= link_new;
                        if (link_new != link_up) link_changes <= link_changes + 1'b1;
                    end else begin
                        error <= 1'b1;
                    end
                    mdio.mdio_valid <= 1'b0;
                    state           <= S_POLL_GAP;
                    tick_cnt        <= '0;
                    us_cnt          <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
                default: state <= S_HOLD;
            endcase
        end
    end
endmodule

// File: tb/tb_phy_init_seq.sv
// Directed bench for phy_init_seq: timing, init writes, polling, timeout,
// restart/ready collision and asynchronous reset.
module tb_phy_init_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       restart = 1'b0;
    logic       phy_reset_n, mdc_clk, init_done, link_up, error;
    logic [7:0] link_changes;
    int         errors = 0;
    int         checks = 0;

    phy_init_seq_if bus();

    phy_init_seq #(
        .CLK_FREQ_HZ(10000000), .RESET_HOLD_US(3), .RESET_WAIT_US(2),
        .MDC_FREQ_HZ(1000000), .PHY_ADDR(5'b00100), .NUM_INIT(2),
        .INIT_TABLE({5'h05, 16'h1234, 5'h00, 16'h8000}),
        .POLL_REG(5'd1), .POLL_MASK(16'h0004), .POLL_INTERVAL_US(2), .MDIO_TIMEOUT(15)
    ) dut (
        .clk(clk), .rst_n(rst_n), .restart(restart),
        .phy_reset_n(phy_reset_n), .mdc_clk(mdc_clk), .mdio(bus),
        .init_done(init_done), .link_up(link_up),
        .link_changes(link_changes), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct { logic [4:0] addr; logic [15:0] wdata; } wr_vec_t;
    typedef struct { logic [15:0] rdata; logic link; logic [7:0] chg; } rd_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.mdio_valid && n < 300) begin step(); n++; end
        if (!bus.mdio_valid) begin
            checks++; errors++;
            $display("FAIL wait_valid: no mdio_valid within %0d cycles", n);
        end
    endtask

    task automatic wait_phy(output int n);
        n = 0;
        while (!phy_reset_n && n < 300) begin step(); n++; end
        if (!phy_reset_n) begin
            checks++; errors++;
            $display("FAIL wait_phy: phy_reset_n stuck low after %0d cycles", n);
        end
    endtask

    // Called on the first sampled cycle of a request; answers after 'delay' cycles
    task automatic serve(input int delay, input logic [15:0] rd);
        logic        stable;
        logic [4:0]  a;
        logic [15:0] w;
        logic        wr;
        stable = 1'b1;
        a = bus.mdio_addr; w = bus.mdio_wdata; wr = bus.mdio_write;
        for (int k = 1; k < delay; k++) begin
            step();
            if (!bus.mdio_valid || bus.mdio_addr !== a || bus.mdio_wdata !== w || bus.mdio_write !== wr)
                stable = 1'b0;
        end
        bus.mdio_ready = 1'b1;
        bus.mdio_rdata = rd;
        step();
        bus.mdio_ready = 1'b0;
        bus.mdio_rdata = 16'h0;
        check("req_stable", stable, 1'b1);
        check("valid_drop", bus.mdio_valid, 1'b0);
    endtask

    initial begin
        wr_vec_t wv[2];
        rd_vec_t rv[4];
        int      n;
        int      mdc_edges[$];
        logic    prev_mdc;

        wv[0] = '{5'h00, 16'h8000};
        wv[1] = '{5'h05, 16'h1234};
        rv[0] = '{16'h0000, 1'b0, 8'd0};
        rv[1] = '{16'h0004, 1'b1, 8'd1};
        rv[2] = '{16'h0004, 1'b1, 8'd1};
        rv[3] = '{16'h0000, 1'b0, 8'd2};
        bus.mdio_ready = 1'b0;
        bus.mdio_rdata = 16'h0;

        repeat (3) step();
        check("rst_phy_reset_n", phy_reset_n, 1'b0);
        check("rst_mdc_clk", mdc_clk, 1'b1);
        check("rst_valid", bus.mdio_valid, 1'b0);
        check("rst_write", bus.mdio_write, 1'b0);
        check("rst_addr", bus.mdio_addr, 5'h0);
        check("rst_wdata", bus.mdio_wdata, 16'h0);
        check("rst_init_done", init_done, 1'b0);
        check("rst_link_up", link_up, 1'b0);
        check("rst_link_changes", link_changes, 8'h0);
        check("rst_error", error, 1'b0);

        // Hold time and MDC waveform
        rst_n = 1'b1;
        n = 0;
        prev_mdc = mdc_clk;
        while (!phy_reset_n && n < 100) begin
            step(); n++;
            if (mdc_clk !== prev_mdc) begin mdc_edges.push_back(n); prev_mdc = mdc_clk; end
        end
        check_rng("hold_time", n, 29, 31);
        check("mdc_edge_count_ok", mdc_edges.size() >= 4, 1'b1);
        if (mdc_edges.size() >= 4)
            for (int i = 1; i < 4; i++)
                check($sformatf("mdc_half_%0d", i), mdc_edges[i] - mdc_edges[i-1], 5);

        // Init table writes
        wait_valid(n);
        check_rng("settle_time", n, 19, 22);
        for (int i = 0; i < 2; i++) begin
            if (i > 0) begin
                wait_valid(n);
                check_rng("wr_idle_gap", n, 1, 5);
            end
            check($sformatf("wr%0d_write", i), bus.mdio_write, 1'b1);
            check($sformatf("wr%0d_phy", i), bus.mdio_phy_addr, 5'b00100);
            check($sformatf("wr%0d_addr", i), bus.mdio_addr, wv[i].addr);
            check($sformatf("wr%0d_wdata", i), bus.mdio_wdata, wv[i].wdata);
            check($sformatf("wr%0d_init_done_pre", i), init_done, 1'b0);
            serve(7, 16'h0);
        end
        check("init_done", init_done, 1'b1);

        // Link polling
        for (int i = 0; i < 4; i++) begin
            wait_valid(n);
            check_rng($sformatf("poll%0d_gap", i), n, 20, 22);
            check($sformatf("poll%0d_write", i), bus.mdio_write, 1'b0);
            check($sformatf("poll%0d_addr", i), bus.mdio_addr, 5'd1);
            serve(3, rv[i].rdata);
            check($sformatf("poll%0d_link_up", i), link_up, rv[i].link);
            check($sformatf("poll%0d_changes", i), link_changes, rv[i].chg);
        end
        check("no_error_yet", error, 1'b0);

        // restart collides with a read completion: completion is dropped
        wait_valid(n);
        bus.mdio_ready = 1'b1;
        bus.mdio_rdata = 16'h0004;
        restart = 1'b1;
        step();
        bus.mdio_ready = 1'b0;
        bus.mdio_rdata = 16'h0;
        restart = 1'b0;
        check("rs_link_up", link_up, 1'b0);
        check("rs_phy_reset_n", phy_reset_n, 1'b0);
        check("rs_valid", bus.mdio_valid, 1'b0);
        check("rs_init_done", init_done, 1'b0);
        check("rs_changes", link_changes, 8'd2);

        // Re-run with a silent engine: both writes time out
        wait_phy(n);
        check_rng("rs_hold_time", n, 29, 31);
        for (int i = 0; i < 2; i++) begin
            wait_valid(n);
            n = 0;
            while (bus.mdio_valid && n < 100) begin step(); n++; end
            check($sformatf("to%0d_valid_cycles", i), n, 15);
            check($sformatf("to%0d_error", i), error, 1'b1);
        end
        check("to_init_done", init_done, 1'b1);
        wait_valid(n);
        check("to_poll_addr", bus.mdio_addr, 5'd1);
        serve(3, 16'h0004);
        check("to_link_up", link_up, 1'b1);
        check("to_changes", link_changes, 8'd3);
        check("to_error_sticky", error, 1'b1);

        // Asynchronous reset in the middle of a write
        restart = 1'b1;
        step();
        restart = 1'b0;
        wait_valid(n);
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        check("ar_valid", bus.mdio_valid, 1'b0);
        check("ar_phy_reset_n", phy_reset_n, 1'b0);
        check("ar_mdc_clk", mdc_clk, 1'b1);
        check("ar_error", error, 1'b0);
        check("ar_changes", link_changes, 8'd0);
        check("ar_init_done", init_done, 1'b0);
        check("ar_link_up", link_up, 1'b0);
        check("ar_addr", bus.mdio_addr, 5'h0);
        step();
        rst_n = 1'b1;
        wait_phy(n);
        check_rng("ar_hold_time", n, 29, 31);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
